// File: rtl/xgmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xgmii_tx_arbiter
//  Purpose  : Frame-level round-robin arbiter sharing one XGMII transmit port
//             between two 72-bit FWFT frame FIFOs ({txc[7:0], txd[63:0]}).
//             Streams whole frames, enforces a minimum idle gap and converts a
//             mid-frame underrun into an XGMII error word.
//  Revision : 1.0 - initial release
// ============================================================================
module xgmii_tx_arbiter #(
   parameter int unsigned IFG_WORDS = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [71:0] in0_dout,
   input  logic        in0_empty,
   output logic        in0_rd_en,
   input  logic [71:0] in1_dout,
   input  logic        in1_empty,
   output logic        in1_rd_en,
   output logic [63:0] xgmii_txd,
   output logic [7:0]  xgmii_txc,
   output logic        grant,
   output logic        busy,
   output logic [31:0] frame_cnt0,
   output logic [31:0] frame_cnt1,
   output logic [15:0] underrun_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam logic [63:0] IDLE_TXD = 64'h0707070707070707;
   localparam logic [63:0] ERR_TXD  = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [7:0]  CTRL_ALL = 8'hFF;
   localparam logic [3:0]  GAP_LOAD = 4'(IFG_WORDS);

   // Start delimiter must sit in lane 0.
   function automatic logic is_start(input logic [71:0] w);
      return w[64] && (w[7:0] == 8'hFB);
   endfunction

   // Terminate may sit in any lane.
   function automatic logic is_term(input logic [71:0] w);
      logic t;
      t = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (w[64+i] && (w[8*i +: 8] == 8'hFD)) t = 1'b1;
      end
      return t;
   endfunction

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic [63:0] txd_q, txd_d;
   logic [7:0]  txc_q, txc_d;
   logic [3:0]  gap_q, gap_d;
   logic [31:0] fcnt0_q, fcnt0_d;
   logic [31:0] fcnt1_q, fcnt1_d;
   logic [15:0] urun_q, urun_d;
   logic        rd0_d, rd1_d;

   logic        ok0, ok1, win0, win1;
   logic [71:0] sel_dout;
   logic        sel_empty;
   logic        sel_term;

   assign ok0  = !in0_empty && is_start(in0_dout);
   assign ok1  = !in1_empty && is_start(in1_dout);
   // grant_q==0 means port 1 has first priority; otherwise port 0 does.
   assign win1 = ok1 && (!grant_q || !ok0);
   assign win0 = ok0 && !win1;

   assign sel_dout  = grant_q ? in1_dout  : in0_dout;
   assign sel_empty = grant_q ? in1_empty : in0_empty;
   assign sel_term  = is_term(sel_dout);

   // Next-state, pop strobes and next output word.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      txd_d   = IDLE_TXD;
      txc_d   = CTRL_ALL;
      gap_d   = gap_q;
      fcnt0_d = fcnt0_q;
      fcnt1_d = fcnt1_q;
      urun_d  = urun_q;
      rd0_d   = 1'b0;
      rd1_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Discard non-start heads; a start head that lost arbitration waits.
            rd0_d = !in0_empty && !(ok0 && !win0);
            rd1_d = !in1_empty && !(ok1 && !win1);
            if (win0 || win1) begin
               grant_d = win1;
               {txc_d, txd_d} = win1 ? in1_dout : in0_dout;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!sel_empty) begin
               if (grant_q) rd1_d = 1'b1;
               else         rd0_d = 1'b1;
               {txc_d, txd_d} = sel_dout;
               if (sel_term) begin
                  if (grant_q) fcnt1_d = fcnt1_q + 32'd1;
                  else         fcnt0_d = fcnt0_q + 32'd1;
                  gap_d   = GAP_LOAD;
                  state_d = ST_GAP;
               end
            end else begin
               txd_d = ERR_TXD;
               if (urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!sel_empty) begin
               if (grant_q) rd1_d = 1'b1;
               else         rd0_d = 1'b1;
               if (sel_term) begin
                  gap_d   = GAP_LOAD;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_q <= 4'd1) state_d = ST_IDLE;
            else               gap_d   = gap_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, output word and counter registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b1;
         txd_q   <= IDLE_TXD;
         txc_q   <= CTRL_ALL;
         gap_q   <= 4'd0;
         fcnt0_q <= 32'd0;
         fcnt1_q <= 32'd0;
         urun_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         txd_q   <= txd_d;
         txc_q   <= txc_d;
         gap_q   <= gap_d;
         fcnt0_q <= fcnt0_d;
         fcnt1_q <= fcnt1_d;
         urun_q  <= urun_d;
      end
   end

   // FIFOs must not be popped while reset is held.
   assign in0_rd_en    = rd0_d && !sys_rst;
   assign in1_rd_en    = rd1_d && !sys_rst;
   assign xgmii_txd    = txd_q;
   assign xgmii_txc    = txc_q;
   assign grant        = grant_q;
   assign busy         = (state_q == ST_SEND) || (state_q == ST_DRAIN);
   assign frame_cnt0   = fcnt0_q;
   assign frame_cnt1   = fcnt1_q;
   assign underrun_cnt = urun_q;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xgmii_tx_arbiter
//  Purpose  : Directed self-checking bench for xgmii_tx_arbiter; FIFOs are
//             modelled as FWFT arrays with read/write pointers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xgmii_tx_arbiter;

   localparam logic [71:0] IDLEW = {8'hFF, 64'h0707070707070707};
   localparam logic [71:0] ERRW  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
   localparam logic [71:0] TERMW = {8'hF8, 64'h07070707FDAABBCC};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [71:0] mem0 [0:255];
   logic [71:0] mem1 [0:255];
   logic [71:0] memb [0:255];
   int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0, wpb = 0, rpb = 0;

   int n_chk = 0;
   int n_fail = 0;

   logic [71:0] a_in0_dout, a_in1_dout, b_in0_dout, b_in1_dout;
   logic        a_in0_empty, a_in1_empty, b_in0_empty;
   logic        a_rd0, a_rd1, b_rd0, b_rd1;
   logic [63:0] a_txd, b_txd;
   logic [7:0]  a_txc, b_txc;
   logic        a_grant, b_grant, a_busy, b_busy;
   logic [31:0] a_fc0, a_fc1, b_fc0, b_fc1;
   logic [15:0] a_ur, b_ur;

   assign a_in0_empty = (wp0 == rp0);
   assign a_in1_empty = (wp1 == rp1);
   assign b_in0_empty = (wpb == rpb);
   assign a_in0_dout  = mem0[rp0[7:0]];
   assign a_in1_dout  = mem1[rp1[7:0]];
   assign b_in0_dout  = memb[rpb[7:0]];
   assign b_in1_dout  = '0;

   xgmii_tx_arbiter #(.IFG_WORDS(1)) dut_a (
      .sys_clk(clk), .sys_rst(rst),
      .in0_dout(a_in0_dout), .in0_empty(a_in0_empty), .in0_rd_en(a_rd0),
      .in1_dout(a_in1_dout), .in1_empty(a_in1_empty), .in1_rd_en(a_rd1),
      .xgmii_txd(a_txd), .xgmii_txc(a_txc), .grant(a_grant), .busy(a_busy),
      .frame_cnt0(a_fc0), .frame_cnt1(a_fc1), .underrun_cnt(a_ur)
   );

   xgmii_tx_arbiter #(.IFG_WORDS(3)) dut_b (
      .sys_clk(clk), .sys_rst(rst),
      .in0_dout(b_in0_dout), .in0_empty(b_in0_empty), .in0_rd_en(b_rd0),
      .in1_dout(b_in1_dout), .in1_empty(1'b1), .in1_rd_en(b_rd1),
      .xgmii_txd(b_txd), .xgmii_txc(b_txc), .grant(b_grant), .busy(b_busy),
      .frame_cnt0(b_fc0), .frame_cnt1(b_fc1), .underrun_cnt(b_ur)
   );

   // FIFO pop model: head advances on each rd_en edge.
   always @(posedge clk) begin
      if (a_rd0) rp0 <= rp0 + 1;
      if (a_rd1) rp1 <= rp1 + 1;
      if (b_rd0) rpb <= rpb + 1;
   end

   function automatic logic [71:0] mk_start(input int p, input int k);
      return {8'h01, 16'h5A5A, p[7:0], k[7:0], 24'h555555, 8'hFB};
   endfunction

   function automatic logic [71:0] mk_data(input int p, input int k);
      return {8'h00, 32'hDA7A0000, p[7:0], k[7:0], 16'h1234};
   endfunction

   task automatic push0(input logic [71:0] w);
      mem0[wp0[7:0]] = w; wp0 = wp0 + 1;
   endtask
   task automatic push1(input logic [71:0] w);
      mem1[wp1[7:0]] = w; wp1 = wp1 + 1;
   endtask
   task automatic pushb(input logic [71:0] w);
      memb[wpb[7:0]] = w; wpb = wpb + 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      push0(mk_data(0, 0));
      @(negedge clk);
      n_chk++;
      if (a_rd0 !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd_en: got %b expected 0", a_rd0);
      end
      n_chk++;
      if ({a_txc, a_txd} !== IDLEW || {b_txc, b_txd} !== IDLEW) begin
         n_fail++; $display("FAIL reset_out: got %h / %h expected %h", {a_txc, a_txd}, {b_txc, b_txd}, IDLEW);
      end
      n_chk++;
      if (a_grant !== 1'b1 || a_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_grant_busy: got %b/%b expected 1/0", a_grant, a_busy);
      end
      n_chk++;
      if (a_fc0 !== 32'd0 || a_fc1 !== 32'd0 || a_ur !== 16'd0) begin
         n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", a_fc0, a_fc1, a_ur);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (rp0 !== wp0) begin
         n_fail++; $display("FAIL reset_garbage_drop: rp=%0d expected %0d", rp0, wp0);
      end
   endtask

   task automatic test_single_frame();
      logic [71:0] f [8];
      int r1;
      f[0] = mk_start(0, 1);
      for (int i = 1; i < 7; i++) f[i] = mk_data(0, i);
      f[7] = TERMW;
      r1 = rp1;
      for (int i = 0; i < 8; i++) push0(f[i]);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== f[i]) begin
            n_fail++; $display("FAIL single_frame word%0d: got %h expected %h", i, {a_txc, a_txd}, f[i]);
         end
         if (i == 0) begin
            n_chk++;
            if (a_busy !== 1'b1) begin
               n_fail++; $display("FAIL single_busy: got %b expected 1", a_busy);
            end
         end
      end
      @(negedge clk);
      n_chk++;
      if ({a_txc, a_txd} !== IDLEW || a_busy !== 1'b0) begin
         n_fail++; $display("FAIL single_ifg: got %h busy %b expected %h busy 0", {a_txc, a_txd}, a_busy, IDLEW);
      end
      @(negedge clk);
      n_chk++;
      if (a_fc0 !== 32'd1 || rp1 !== r1 || a_grant !== 1'b0) begin
         n_fail++; $display("FAIL single_cnt: fc0=%0d in1_pops=%0d grant=%b expected 1/0/0", a_fc0, rp1 - r1, a_grant);
      end
   endtask

   task automatic test_alternate();
      logic [71:0] e;
      int p, k;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push0(mk_start(0, i)); push0(mk_data(0, i)); push0(TERMW);
         push1(mk_start(1, i)); push1(mk_data(1, i)); push1(TERMW);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         p = n % 2; k = n / 2;
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            case (j)
               0:       e = mk_start(p, k);
               1:       e = mk_data(p, k);
               2:       e = TERMW;
               default: e = IDLEW;
            endcase
            n_chk++;
            if ({a_txc, a_txd} !== e) begin
               n_fail++; $display("FAIL alternate frame%0d word%0d: got %h expected %h", n, j, {a_txc, a_txd}, e);
            end
         end
      end
      n_chk++;
      if (a_fc0 !== 32'd4 || a_fc1 !== 32'd4 || a_grant !== 1'b1) begin
         n_fail++; $display("FAIL alternate_cnt: got %0d/%0d grant %b expected 4/4 grant 1", a_fc0, a_fc1, a_grant);
      end
   endtask

   task automatic test_underrun();
      logic [71:0] f [3];
      f[0] = mk_start(1, 9); f[1] = mk_data(1, 1); f[2] = mk_data(1, 2);
      for (int i = 0; i < 3; i++) push1(f[i]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== f[i]) begin
            n_fail++; $display("FAIL underrun word%0d: got %h expected %h", i, {a_txc, a_txd}, f[i]);
         end
      end
      @(negedge clk);
      n_chk++;
      if ({a_txc, a_txd} !== ERRW || a_ur !== 16'd1 || a_busy !== 1'b1) begin
         n_fail++; $display("FAIL underrun_err: got %h ur=%0d busy=%b expected %h ur=1 busy=1", {a_txc, a_txd}, a_ur, a_busy, ERRW);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== IDLEW) begin
            n_fail++; $display("FAIL underrun_wait%0d: got %h expected %h", i, {a_txc, a_txd}, IDLEW);
         end
      end
      push1(mk_data(1, 3)); push1(mk_start(1, 4)); push1(TERMW);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== IDLEW) begin
            n_fail++; $display("FAIL underrun_drain%0d: got %h expected %h", i, {a_txc, a_txd}, IDLEW);
         end
      end
      n_chk++;
      if (a_busy !== 1'b0 || rp1 !== wp1 || a_fc1 !== 32'd4 || a_ur !== 16'd1) begin
         n_fail++; $display("FAIL underrun_end: busy=%b left=%0d fc1=%0d ur=%0d expected 0/0/4/1", a_busy, wp1 - rp1, a_fc1, a_ur);
      end
   endtask

   task automatic test_garbage();
      logic [71:0] f [4];
      int base;
      f[0] = mk_start(0, 7); f[1] = mk_data(0, 7); f[2] = mk_data(0, 8); f[3] = TERMW;
      base = rp0;
      for (int i = 0; i < 3; i++) push0(mk_data(0, 40 + i));
      for (int i = 0; i < 4; i++) push0(f[i]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== IDLEW) begin
            n_fail++; $display("FAIL garbage_idle%0d: got %h expected %h", i, {a_txc, a_txd}, IDLEW);
         end
      end
      n_chk++;
      if (rp0 !== base + 3) begin
         n_fail++; $display("FAIL garbage_pops: got %0d expected 3", rp0 - base);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== f[i]) begin
            n_fail++; $display("FAIL garbage_frame word%0d: got %h expected %h", i, {a_txc, a_txd}, f[i]);
         end
      end
      @(negedge clk);
      n_chk++;
      if ({a_txc, a_txd} !== IDLEW || a_fc0 !== 32'd5) begin
         n_fail++; $display("FAIL garbage_end: got %h fc0=%0d expected %h fc0=5", {a_txc, a_txd}, a_fc0, IDLEW);
      end
   endtask

   task automatic test_back_to_back();
      logic [71:0] e [10];
      e[0] = mk_start(0, 1); e[1] = mk_data(0, 1); e[2] = TERMW;
      e[3] = IDLEW; e[4] = IDLEW; e[5] = IDLEW;
      e[6] = mk_start(0, 2); e[7] = mk_data(0, 2); e[8] = TERMW; e[9] = IDLEW;
      pushb(e[0]); pushb(e[1]); pushb(e[2]);
      pushb(e[6]); pushb(e[7]); pushb(e[8]);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_chk++;
         if ({b_txc, b_txd} !== e[i]) begin
            n_fail++; $display("FAIL back_to_back word%0d: got %h expected %h", i, {b_txc, b_txd}, e[i]);
         end
      end
      n_chk++;
      if (b_fc0 !== 32'd2) begin
         n_fail++; $display("FAIL back_to_back_cnt: got %0d expected 2", b_fc0);
      end
   endtask

   task automatic test_reset_midframe();
      logic [71:0] f [8];
      int r;
      f[0] = mk_start(0, 3);
      for (int i = 1; i < 7; i++) f[i] = mk_data(0, 50 + i);
      f[7] = TERMW;
      for (int i = 0; i < 8; i++) push0(f[i]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== f[i]) begin
            n_fail++; $display("FAIL midreset word%0d: got %h expected %h", i, {a_txc, a_txd}, f[i]);
         end
      end
      rst = 1'b1;
      r = rp0;
      @(negedge clk);
      n_chk++;
      if ({a_txc, a_txd} !== IDLEW || a_rd0 !== 1'b0 || rp0 !== r) begin
         n_fail++; $display("FAIL midreset_out: got %h rd=%b pops=%0d expected %h rd=0 pops=0", {a_txc, a_txd}, a_rd0, rp0 - r, IDLEW);
      end
      n_chk++;
      if (a_fc0 !== 32'd0 || a_fc1 !== 32'd0 || a_ur !== 16'd0 || a_grant !== 1'b1 || a_busy !== 1'b0) begin
         n_fail++; $display("FAIL midreset_state: fc0=%0d fc1=%0d ur=%0d grant=%b busy=%b expected 0/0/0/1/0", a_fc0, a_fc1, a_ur, a_grant, a_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_txc, a_txd} !== IDLEW) begin
            n_fail++; $display("FAIL midreset_after%0d: got %h expected %h", i, {a_txc, a_txd}, IDLEW);
         end
      end
      n_chk++;
      if (rp0 !== wp0 || a_fc0 !== 32'd0) begin
         n_fail++; $display("FAIL midreset_flush: left=%0d fc0=%0d expected 0/0", wp0 - rp0, a_fc0);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_alternate();
      test_underrun();
      test_garbage();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
